regfile_mp: RTL



---
 rtl/regfile_mp.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, two write lanes, optional zero register,
// write-to-read bypass and registered reads. The array is zeroed by a one-entry-per-cycle clear sequence.
module regfile_mp #(
  parameter int WIDTH     = 32,
  parameter int RSELWIDTH = 4,
  parameter int NRD       = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int REG_READ  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we0,
  input  logic [RSELWIDTH-1:0]     wsel0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [RSELWIDTH-1:0]     wsel1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [NRD*RSELWIDTH-1:0] rsel,
  output logic [NRD*WIDTH-1:0]     rdata,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int                   DEPTH    = 2**RSELWIDTH;
  localparam logic [RSELWIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state, state_nxt;
  logic [RSELWIDTH-1:0] clr_idx, clr_idx_nxt;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 wr_open, acc0, acc1;
  logic [RSELWIDTH-1:0] sel;
  logic [NRD*WIDTH-1:0] rd_comb;

  // A lane write is accepted only in READY without a clear request; writes to
  // the hardwired zero entry are swallowed without being reported as drops.
  assign wr_open = (state == READY) && !clr;
  assign acc0    = wr_open && we0 && !((ZERO_REG != 0) && (wsel0 == '0));
  assign acc1    = wr_open && we1 && !((ZERO_REG != 0) && (wsel1 == '0));
  assign busy    = (state == CLEAR);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    unique case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr)                        clr_idx_nxt = '0;
        else if (clr_idx == LAST_IDX)   state_nxt   = READY;
      end
      READY: begin
        if (clr) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      wr_drop <= !wr_open && (we0 || we1);
    end
  end

  // NOTE: the array has no reset term; the clear sequence zeroes it, which keeps it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      // NOTE: non-blocking assignments to the same entry resolve to the last one, so lane 1 wins a collision.
      if (acc0) mem[wsel0] <= wdata0;
      if (acc1) mem[wsel1] <= wdata1;
    end
  end

  always_comb begin
    rd_comb = '0;
    sel     = '0;
    for (int i = 0; i < NRD; i++) begin
      sel = rsel[i*RSELWIDTH +: RSELWIDTH];
      if (busy || ((ZERO_REG != 0) && (sel == '0)))
        rd_comb[i*WIDTH +: WIDTH] = '0;
      else if ((BYPASS != 0) && acc1 && (wsel1 == sel))
        rd_comb[i*WIDTH +: WIDTH] = wdata1;
      else if ((BYPASS != 0) && acc0 && (wsel0 == sel))
        rd_comb[i*WIDTH +: WIDTH] = wdata0;
      else
        rd_comb[i*WIDTH +: WIDTH] = mem[sel];
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NRD*WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rd_comb;
    end
    assign rdata = rdata_q;
  end else begin : g_comb_read
    assign rdata = rd_comb;
  end

endmodule
